seq_pattern_detector: RTL and testbench

// - Serial bit-pattern detector: samples 1-bit stream `in` on every rising clk edge, flags

---
 rtl/seq_pattern_detector_if.sv | 7 +
 rtl/seq_pattern_detector.sv | 88 ++++++++
 tb/tb_seq_pattern_detector.sv | 133 +++++++++++++
 3 files changed

// File: rtl/seq_pattern_detector_if.sv
// seq_pattern_detector_if: serial data in / match strobe out bundle for the pattern detector
interface seq_pattern_detector_if;
    logic in;
    logic out;
    modport master (output in, input out);
    modport slave (input in, output out);
endinterface

// File: rtl/seq_pattern_detector.sv
// seq_pattern_detector: serial bit-pattern detector driven by a KMP-style next-state table built at elaboration
module seq_pattern_detector #(
    parameter int PATTERN_W = 4,
    parameter logic [PATTERN_W-1:0] PATTERN = 4'b1011,
    parameter bit OVERLAP = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    seq_pattern_detector_if.slave bus
);
    localparam int SW = $clog2(PATTERN_W);
    localparam int NS = 1 << SW;

    // Longest suffix of (first s pattern bits followed by b) that is also a prefix of PATTERN.
    // A result of PATTERN_W means the bit completes a full match.
    function automatic int ext_len(input int s, input int b);
        logic [16:0] seq;
        int best;
        bit ok;
        seq = '0;
        best = 0;
        if (s >= PATTERN_W) return 0;
        for (int i = 0; i < s; i++) seq[i] = PATTERN[PATTERN_W-1-i];
        seq[s] = b[0];
        for (int k = 1; k <= s + 1; k++) begin
            ok = 1'b1;
            for (int j = 0; j < k; j++)
                if (seq[s+1-k+j] != PATTERN[PATTERN_W-1-j]) ok = 1'b0;
            if (ok) best = k;
        end
        return best;
    endfunction

    // Longest proper border of the whole pattern: where an overlapping search resumes.
    function automatic int border_len();
        int best;
        bit ok;
        best = 0;
        for (int k = 1; k < PATTERN_W; k++) begin
            ok = 1'b1;
            for (int j = 0; j < k; j++)
                if (PATTERN[k-1-j] != PATTERN[PATTERN_W-1-j]) ok = 1'b0;
            if (ok) best = k;
        end
        return best;
    endfunction

    localparam int BORDER = border_len();

    logic [SW-1:0] nxt_tab [NS][2];
    logic          hit_tab [NS][2];
    logic [SW-1:0] state;
    logic [SW-1:0] state_next;
    logic          match;
    logic          out_q;

    // Unreachable encodings (when PATTERN_W is not a power of two) fall back to state 0.
    for (genvar i = 0; i < NS; i++) begin : g_s
        for (genvar j = 0; j < 2; j++) begin : g_b
            localparam int L = ext_len(i, j);
            assign hit_tab[i][j] = (L == PATTERN_W);
            assign nxt_tab[i][j] = (L == PATTERN_W) ? SW'(OVERLAP ? BORDER : 0) : SW'(L);
        end
    end

    // State register and registered match strobe; async reset clears all history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= '0;
            out_q <= 1'b0;
        end else begin
            state <= state_next;
            out_q <= match;
        end
    end

    // Next state: table lookup on current prefix length and incoming bit.
    always_comb begin
        state_next = nxt_tab[state][bus.in];
    end

    // Output decode: this bit completes the pattern.
    always_comb begin
        match = hit_tab[state][bus.in];
    end

    assign bus.out = out_q;
endmodule

// File: tb/tb_seq_pattern_detector.sv
// tb_seq_pattern_detector: directed and random checks of the serial pattern detector
module tb_seq_pattern_detector;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic din = 1'b0;
    int tests = 0;
    int fails = 0;

    seq_pattern_detector_if if_a ();
    seq_pattern_detector_if if_b ();
    seq_pattern_detector_if if_c ();
    seq_pattern_detector_if if_d ();

    assign if_a.in = din;
    assign if_b.in = din;
    assign if_c.in = din;
    assign if_d.in = din;

    seq_pattern_detector #(.PATTERN_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
    seq_pattern_detector #(.PATTERN_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
    seq_pattern_detector #(.PATTERN_W(3), .PATTERN(3'b111), .OVERLAP(1'b1)) dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));
    seq_pattern_detector #(.PATTERN_W(3), .PATTERN(3'b111), .OVERLAP(1'b0)) dut_d (.clk(clk), .rst_n(rst_n), .bus(if_d));

    always #5 clk = ~clk;

    task automatic check(input string tag, input string inst, input logic got, input logic exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s_%s: out=%b expected %b", tag, inst, got, exp);
        end
    endtask

    task automatic step(input logic b);
        din = b;
        @(posedge clk);
        #1;
    endtask

    task automatic hold_release(input string tag);
        for (int i = 0; i < 3; i++) begin
            din = i[0];
            @(posedge clk);
            #1;
            check(tag, "a", if_a.out, 1'b0);
            check(tag, "b", if_b.out, 1'b0);
            check(tag, "c", if_c.out, 1'b0);
            check(tag, "d", if_d.out, 1'b0);
        end
        din = 1'bx;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        hold_release("rst_hold");
    endtask

    task automatic run_seq(input string tag, input int n, input logic [31:0] bits,
                           input logic [31:0] e0, input logic [31:0] e1, input bit sweep);
        do_reset();
        for (int i = n - 1; i >= 0; i--) begin
            step(bits[i]);
            if (sweep) begin
                check(tag, "c", if_c.out, e0[i]);
                check(tag, "d", if_d.out, e1[i]);
            end else begin
                check(tag, "a", if_a.out, e0[i]);
                check(tag, "b", if_b.out, e1[i]);
            end
        end
    endtask

    initial begin
        logic [3:0] hist;
        int va;
        int vb;
        logic ea;
        logic eb;
        logic b;
        do_reset();
        run_seq("basic", 4, 32'b1011, 32'b0001, 32'b0001, 1'b0);
        run_seq("overlap", 7, 32'b1011011, 32'b0001001, 32'b0001000, 1'b0);
        run_seq("fallback6", 6, 32'b101011, 32'b000001, 32'b000001, 1'b0);
        run_seq("fallback5", 5, 32'b11011, 32'b00001, 32'b00001, 1'b0);
        run_seq("zeros", 4, 32'b0000, 32'b0000, 32'b0000, 1'b0);
        run_seq("ones", 4, 32'b1111, 32'b0000, 32'b0000, 1'b0);
        run_seq("sweep111", 5, 32'b11111, 32'b00111, 32'b00100, 1'b1);
        do_reset();
        step(1'b1);
        step(1'b0);
        step(1'b1);
        step(1'b1);
        check("pre_async", "a", if_a.out, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async_clear", "a", if_a.out, 1'b0);
        check("async_clear", "b", if_b.out, 1'b0);
        hold_release("async_hold");
        do_reset();
        step(1'b1);
        step(1'b0);
        step(1'b1);
        #2 rst_n = 1'b0;
        hold_release("s3_hold");
        step(1'b0);
        check("post_rst", "a", if_a.out, 1'b0);
        step(1'b1);
        check("post_rst", "a", if_a.out, 1'b0);
        step(1'b1);
        check("post_rst", "a", if_a.out, 1'b0);
        check("post_rst", "b", if_b.out, 1'b0);
        do_reset();
        hist = '0;
        va = 0;
        vb = 0;
        for (int i = 0; i < 60; i++) begin
            b = 1'($urandom_range(0, 1));
            step(b);
            hist = {hist[2:0], b};
            if (va < 4) va++;
            vb++;
            ea = (va >= 4) && (hist == 4'b1011);
            eb = (vb >= 4) && (hist == 4'b1011);
            if (eb) vb = 0;
            check("random", "a", if_a.out, ea);
            check("random", "b", if_b.out, eb);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
